fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the 16-entry FIFO between two producers.
- Grants bursts round-robin and throttles bursts when the FIFO status reports the threshold.
- Never issues a write while the FIFO is full, so the FIFO overflow flag cannot be set by this path.
- Sits between the producer interfaces and the FIFO wr/data_in inputs; consumes fifo_full and fifo_threshold from the status logic.

---
 rtl/fifo_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares the single write port of a small FIFO between two producers.
// Ownership is granted in round-robin bursts of up to MAX_BURST beats.
// A burst is cut short to one beat while the FIFO reports its threshold.
// No write is ever issued while the FIFO is full; the owner simply stalls.
// Per-producer saturating counters record cycles spent valid but not accepted.

module fifo_wr_arbiter #(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              fifo_full,
   input  logic              fifo_threshold,
   output logic              wr,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        gnt,
   output logic [CNT_W-1:0]  stall0_cnt,
   output logic [CNT_W-1:0]  stall1_cnt
);

   // State encoding doubles as the one-hot grant vector.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_OWN0 = 2'b01;
   localparam logic [1:0] ST_OWN1 = 2'b10;

   // Beat count at which the current write completes a full burst.
   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [3:0]        r_beat_cnt;
   logic [3:0]        w_beat_cnt_next;
   logic              r_last;
   logic              w_last_next;

   logic [1:0]        w_valid;
   logic [1:0]        w_ready;
   logic [1:0]        w_own;
   logic [DATA_W-1:0] w_data [2];
   logic [CNT_W-1:0]  r_stall_cnt [2];

   logic              w_own_idx;
   logic              w_wr;
   logic              w_owner_valid;
   logic              w_other_valid;
   logic              w_burst_end;
   logic              w_release;

   assign w_valid   = {req1_valid, req0_valid};
   assign w_data[0] = req0_data;
   assign w_data[1] = req1_data;
   assign w_own     = r_state;
   assign w_own_idx = r_state[1];

   // Per-producer accept and stall accounting.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_prod
         // Only the owner may be accepted, never into a full FIFO, never during reset.
         assign w_ready[gi] = !rst && w_own[gi] && !fifo_full;

         // Count cycles the producer waits with a beat pending; saturate at all-ones.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_stall_cnt[gi] <= '0;
            end else if (w_valid[gi] && !w_ready[gi] && (r_stall_cnt[gi] != {CNT_W{1'b1}})) begin
               r_stall_cnt[gi] <= r_stall_cnt[gi] + 1'b1;
            end
         end
      end
   endgenerate

   assign w_wr          = |(w_ready & w_valid);
   assign w_owner_valid = |(w_valid & w_own);
   // Swap the ownership bits to find the valid of the producer that is waiting.
   assign w_other_valid = |(w_valid & {w_own[0], w_own[1]});
   // A write ends the burst either on its last beat or when the FIFO is filling up.
   assign w_burst_end   = w_wr && ((r_beat_cnt == BURST_LAST) || fifo_threshold);
   assign w_release     = (r_state != ST_IDLE) && (!w_owner_valid || w_burst_end);

   assign req0_ready = w_ready[0];
   assign req1_ready = w_ready[1];
   assign wr         = w_wr;
   assign data_out   = w_wr ? w_data[w_own_idx] : '0;
   assign gnt        = r_state;
   assign stall0_cnt = r_stall_cnt[0];
   assign stall1_cnt = r_stall_cnt[1];

   // Next grant, burst count and round-robin pointer.
   always_comb begin
      w_state_next    = r_state;
      w_beat_cnt_next = r_beat_cnt + {3'b000, w_wr};
      w_last_next     = r_last;
      case (r_state)
         ST_IDLE: begin
            w_beat_cnt_next = '0;
            if (req0_valid && req1_valid) begin
               // Tie goes to whoever was not served most recently.
               w_state_next = r_last ? ST_OWN0 : ST_OWN1;
               w_last_next  = !r_last;
            end else if (req0_valid) begin
               w_state_next = ST_OWN0;
               w_last_next  = 1'b0;
            end else if (req1_valid) begin
               w_state_next = ST_OWN1;
               w_last_next  = 1'b1;
            end
         end
         ST_OWN0, ST_OWN1: begin
            if (w_release) begin
               w_beat_cnt_next = '0;
               if (w_other_valid) begin
                  // Hand straight over to the waiting producer, no idle bubble.
                  w_state_next = {w_own[0], w_own[1]};
                  w_last_next  = !w_own_idx;
               end else if (w_owner_valid) begin
                  // Burst ended by length or threshold with nobody else waiting: new burst.
                  w_state_next = r_state;
                  w_last_next  = w_own_idx;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_next    = ST_IDLE;
            w_beat_cnt_next = '0;
         end
      endcase
   end

   // Grant state registers; reset leaves the arbiter idle with producer 0 favoured.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_beat_cnt <= '0;
         r_last     <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_beat_cnt <= w_beat_cnt_next;
         r_last     <= w_last_next;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: cycle table, directed corner sequences,
// and a randomized run against a behavioural model.

module tb_fifo_wr_arbiter;

   localparam int DW = 8;
   localparam int MB = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [DW-1:0] req0_data, req1_data, data_out;
   logic          fifo_full, fifo_threshold, wr;
   logic [1:0]    gnt;
   logic [CW-1:0] stall0_cnt, stall1_cnt;

   int total = 0;
   int bad   = 0;

   fifo_wr_arbiter #(.DATA_W(DW), .MAX_BURST(MB), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .fifo_full(fifo_full), .fifo_threshold(fifo_threshold),
      .wr(wr), .data_out(data_out), .gnt(gnt),
      .stall0_cnt(stall0_cnt), .stall1_cnt(stall1_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v0, v1, full, thr;
      logic [1:0] gnt;
      logic       wr, r0, r1;
      logic [7:0] dout;
   } vec_t;

   vec_t tbl [25];

   function automatic vec_t mk(input logic v0, v1, full, thr, input logic [1:0] g,
                               input logic w, r0, r1, input logic [7:0] d);
      vec_t t;
      t.v0 = v0; t.v1 = v1; t.full = full; t.thr = thr;
      t.gnt = g; t.wr = w; t.r0 = r0; t.r1 = r1; t.dout = d;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req0_valid = 0; req1_valid = 0; fifo_full = 0; fifo_threshold = 0;
      req0_data = 0; req1_data = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Behavioural reference: owner is -1 (none), 0 or 1.
   int         m_own, m_beats, m_last;
   int         m_stall [2];
   logic [6:0] seq [2];
   logic       m_rdy [2];
   logic       m_wr;
   logic [7:0] m_dout;

   task automatic model_eval();
      logic v [2];
      logic [7:0] d [2];
      v[0] = req0_valid; v[1] = req1_valid; d[0] = req0_data; d[1] = req1_data;
      for (int i = 0; i < 2; i++) m_rdy[i] = !rst && (m_own == i) && !fifo_full;
      m_wr = 0; m_dout = 0;
      if (m_own >= 0 && m_rdy[m_own] && v[m_own]) begin
         m_wr = 1; m_dout = d[m_own];
      end
   endtask

   task automatic model_step();
      logic v [2];
      int o;
      v[0] = req0_valid; v[1] = req1_valid;
      if (rst) begin
         m_own = -1; m_beats = 0; m_last = 1; m_stall[0] = 0; m_stall[1] = 0;
         return;
      end
      for (int i = 0; i < 2; i++)
         if (v[i] && !m_rdy[i] && m_stall[i] < 255) m_stall[i]++;
      if (m_wr) seq[m_own] = seq[m_own] + 7'd1;
      if (m_own < 0) begin
         o = -1;
         if (v[0] && v[1]) o = 1 - m_last;
         else if (v[0]) o = 0;
         else if (v[1]) o = 1;
         if (o >= 0) begin m_own = o; m_last = o; m_beats = 0; end
      end else begin
         o = m_own;
         if (!v[o] || (m_wr && (m_beats + 1 == MB || fifo_threshold))) begin
            m_beats = 0;
            if (v[1-o]) begin m_own = 1 - o; m_last = 1 - o; end
            else if (v[o]) m_last = o;
            else m_own = -1;
         end else if (m_wr) begin
            m_beats++;
         end
      end
   endtask

   initial begin
      rst = 1; req0_valid = 0; req1_valid = 0; fifo_full = 0; fifo_threshold = 0;
      req0_data = 0; req1_data = 0;

      // Hand-derived cycle table: both producers busy, then threshold, full, drop-outs.
      tbl[0] = mk(1,1,0,0, 2'b00, 0,0,0, 8'h00);
      for (int i = 1; i <= 4; i++)  tbl[i] = mk(1,1,0,0, 2'b01, 1,1,0, 8'h0A);
      for (int i = 5; i <= 8; i++)  tbl[i] = mk(1,1,0,0, 2'b10, 1,0,1, 8'h0B);
      tbl[9]  = mk(1,1,0,0, 2'b01, 1,1,0, 8'h0A);
      tbl[10] = mk(1,1,0,1, 2'b01, 1,1,0, 8'h0A);
      tbl[11] = mk(1,1,0,1, 2'b10, 1,0,1, 8'h0B);
      tbl[12] = mk(1,1,0,1, 2'b01, 1,1,0, 8'h0A);
      for (int i = 13; i <= 15; i++) tbl[i] = mk(1,1,1,0, 2'b10, 0,0,0, 8'h00);
      for (int i = 16; i <= 19; i++) tbl[i] = mk(1,1,0,0, 2'b10, 1,0,1, 8'h0B);
      tbl[20] = mk(1,1,0,0, 2'b01, 1,1,0, 8'h0A);
      tbl[21] = mk(0,1,0,0, 2'b01, 0,1,0, 8'h00);
      tbl[22] = mk(0,0,0,0, 2'b10, 0,0,1, 8'h00);
      tbl[23] = mk(0,1,0,0, 2'b00, 0,0,0, 8'h00);
      tbl[24] = mk(0,1,0,0, 2'b10, 1,0,1, 8'h0B);

      // Reset state.
      do_reset();
      #1;
      chk("reset gnt", 32'(gnt), 0);
      chk("reset wr", 32'(wr), 0);
      chk("reset data", 32'(data_out), 0);
      chk("reset stall0", 32'(stall0_cnt), 0);
      chk("reset stall1", 32'(stall1_cnt), 0);

      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         req0_valid = tbl[c].v0; req1_valid = tbl[c].v1;
         fifo_full = tbl[c].full; fifo_threshold = tbl[c].thr;
         req0_data = 8'h0A; req1_data = 8'h0B;
         #1;
         chk($sformatf("tbl%0d gnt", c), 32'(gnt), 32'(tbl[c].gnt));
         chk($sformatf("tbl%0d wr", c), 32'(wr), 32'(tbl[c].wr));
         chk($sformatf("tbl%0d rdy0", c), 32'(req0_ready), 32'(tbl[c].r0));
         chk($sformatf("tbl%0d rdy1", c), 32'(req1_ready), 32'(tbl[c].r1));
         chk($sformatf("tbl%0d data", c), 32'(data_out), 32'(tbl[c].dout));
      end
      chk("tbl stall0", 32'(stall0_cnt), 13);
      chk("tbl stall1", 32'(stall1_cnt), 14);

      // Single producer, six beats: one bubble, burst of 4, re-grant, then idle.
      do_reset();
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         req0_valid = (c <= 6);
         req0_data = (c == 0) ? 8'h10 : 8'(8'h10 + c - 1);
         #1;
         chk($sformatf("solo%0d wr", c), 32'(wr), 32'((c >= 1) && (c <= 6)));
         if (c >= 1 && c <= 6) chk($sformatf("solo%0d data", c), 32'(data_out), 32'(8'h10 + c - 1));
         chk($sformatf("solo%0d gnt", c), 32'(gnt), (c == 0 || c == 8) ? 0 : 1);
      end
      chk("solo stall0", 32'(stall0_cnt), 1);

      // Reset during the second beat of a producer-1 burst.
      do_reset();
      @(negedge clk); req1_valid = 1; req1_data = 8'h55;
      @(negedge clk); #1;
      chk("rstmid beat1 wr", 32'(wr), 1);
      @(negedge clk); rst = 1; #1;
      chk("rstmid reset-cycle wr", 32'(wr), 0);
      @(negedge clk); rst = 0; req0_valid = 1; req1_valid = 1; #1;
      chk("rstmid gnt", 32'(gnt), 0);
      chk("rstmid wr", 32'(wr), 0);
      chk("rstmid stall0", 32'(stall0_cnt), 0);
      chk("rstmid stall1", 32'(stall1_cnt), 0);
      @(negedge clk); #1;
      chk("rstmid first gnt", 32'(gnt), 1);

      // Long full stall saturates the counter and never writes.
      do_reset();
      for (int c = 0; c < 300; c++) begin
         @(negedge clk); req1_valid = 1; fifo_full = 1; #1;
         if (wr !== 1'b0) chk($sformatf("sat%0d wr", c), 32'(wr), 0);
      end
      chk("sat wr end", 32'(wr), 0);
      chk("sat stall1", 32'(stall1_cnt), 255);

      // Randomized run against the reference model.
      seq[0] = 0; seq[1] = 0;
      m_own = -1; m_beats = 0; m_last = 1; m_stall[0] = 0; m_stall[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst = (c == 0) || ($urandom_range(0, 299) == 0);
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         fifo_full = ($urandom_range(0, 5) == 0);
         fifo_threshold = ($urandom_range(0, 3) == 0);
         req0_data = {1'b0, seq[0]};
         req1_data = {1'b1, seq[1]};
         #1;
         model_eval();
         if (c > 0) begin
            chk($sformatf("rnd%0d gnt", c), 32'(gnt),
                (m_own < 0) ? 0 : ((m_own == 0) ? 1 : 2));
            chk($sformatf("rnd%0d wr", c), 32'(wr), 32'(m_wr));
            chk($sformatf("rnd%0d data", c), 32'(data_out), 32'(m_dout));
            chk($sformatf("rnd%0d rdy0", c), 32'(req0_ready), 32'(m_rdy[0]));
            chk($sformatf("rnd%0d rdy1", c), 32'(req1_ready), 32'(m_rdy[1]));
            chk($sformatf("rnd%0d stall0", c), 32'(stall0_cnt), 32'(m_stall[0]));
            chk($sformatf("rnd%0d stall1", c), 32'(stall1_cnt), 32'(m_stall[1]));
         end
         model_step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
